// File: rtl/mc_pkg.sv
// mc_pkg: states, opcodes and datapath select encodings
// shared by the multicycle RV32I controller.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_LUI,
    S_ALU_WB,
    S_BRANCH,
    S_JALR_ADDR,
    S_JUMP,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] SA_PC    = 2'b00;
  localparam logic [1:0] SA_OLDPC = 2'b01;
  localparam logic [1:0] SA_A     = 2'b10;
  localparam logic [1:0] SA_ZERO  = 2'b11;

  localparam logic [1:0] SB_B    = 2'b00;
  localparam logic [1:0] SB_IMM  = 2'b01;
  localparam logic [1:0] SB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] TC_NONE = 2'b00;
  localparam logic [1:0] TC_ILL  = 2'b01;
  localparam logic [1:0] TC_TMO  = 2'b10;

  // alt selects sub/sra where funct7 = 0x20
  function automatic logic [3:0] alu_of(
    input logic [2:0] f3,
    input logic       alt
  );
    case (f3)
      3'b000:  alu_of = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_of = ALU_SLL;
      3'b010:  alu_of = ALU_SLT;
      3'b011:  alu_of = ALU_SLTU;
      3'b100:  alu_of = ALU_XOR;
      3'b101:  alu_of = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_of = ALU_OR;
      default: alu_of = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/mc_controller_hs_alu_dec.sv
// mc_alu_dec: ALU operation decode and illegal
// encoding detection from the IR fields.
module mc_alu_dec
  import mc_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] alu_ctrl,
  output logic       illegal
);

  logic f7z;
  logic f7a;

  assign f7z = (funct7 == 7'h00);
  assign f7a = (funct7 == 7'h20);

  always_comb begin
    alu_ctrl = ALU_ADD;
    illegal  = 1'b0;
    case (op)
      OP_R: begin
        alu_ctrl = alu_of(funct3, f7a);
        illegal  = !(f7z || (f7a &&
                   (funct3 == 3'b000 ||
                    funct3 == 3'b101)));
      end
      OP_IMM: begin
        alu_ctrl = alu_of(funct3,
                          f7a && funct3 == 3'b101);
        if (funct3 == 3'b001)
          illegal = !f7z;
        else if (funct3 == 3'b101)
          illegal = !(f7z || f7a);
      end
      OP_BRANCH:
        illegal = (funct3[2:1] == 2'b01);
      OP_LOAD, OP_STORE:
        illegal = (funct3 != 3'b010);
      OP_JALR:
        illegal = (funct3 != 3'b000);
      OP_JAL, OP_LUI, OP_AUIPC:
        illegal = 1'b0;
      default:
        illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_controller_hs.sv
// mc_controller_hs: multicycle RV32I control FSM with memory
// handshake and traps; MC_PERF_CNT_EN adds the instret counter.
module mc_controller_hs
  import mc_pkg::*;
#(
  parameter int TIMEOUT_W = 8
`ifdef MC_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic [3:0] alu_control,
  output logic       halted,
  output logic [1:0] trap_cause
`ifdef MC_PERF_CNT_EN
  , output logic [CNT_W-1:0] instret
`endif
);

  state_t               state;
  state_t               state_nxt;
  logic [1:0]           cause_nxt;
  logic [TIMEOUT_W-1:0] wcnt;
  logic [TIMEOUT_W-1:0] wcnt_inc;
  logic                 waiting;
  logic                 tmo;
  logic                 br_take;
  logic [3:0]           dec_alu;
  logic                 dec_ill;

  mc_alu_dec u_dec (
    .op       (op),
    .funct3   (funct3),
    .funct7   (funct7),
    .alu_ctrl (dec_alu),
    .illegal  (dec_ill)
  );

  assign wcnt_inc = wcnt + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
  assign waiting  = !mem_ready &&
                    (state == S_FETCH  ||
                     state == S_MEM_RD ||
                     state == S_MEM_WR);
  // trap on the not-ready cycle that brings the count to all-ones
  assign tmo      = waiting && (&wcnt_inc);

  always_comb begin
    br_take = 1'b0;
    case (funct3)
      3'b000:  br_take = zero;
      3'b001:  br_take = !zero;
      3'b100:  br_take = lt;
      3'b101:  br_take = !lt;
      3'b110:  br_take = ltu;
      3'b111:  br_take = !ltu;
      default: br_take = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    cause_nxt   = TC_NONE;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SA_PC;
    alu_src_b   = SB_B;
    imm_src     = IMM_I;
    alu_control = ALU_ADD;
    halted      = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = SB_FOUR;
          result_src = RES_ALU;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
          if (mem_ready) begin
            state_nxt = S_DECODE;
          end else if (tmo) begin
            state_nxt = S_TRAP;
            cause_nxt = TC_TMO;
          end
        end
        S_DECODE: begin
          alu_src_a = SA_OLDPC;
          alu_src_b = SB_IMM;
          case (op)
            OP_BRANCH: imm_src = IMM_B;
            OP_JAL:    imm_src = IMM_J;
            OP_AUIPC:  imm_src = IMM_U;
            default:   imm_src = IMM_I;
          endcase
          if (dec_ill) begin
            state_nxt = S_TRAP;
            cause_nxt = TC_ILL;
          end else begin
            case (op)
              OP_R:      state_nxt = S_EXEC_R;
              OP_IMM:    state_nxt = S_EXEC_I;
              OP_BRANCH: state_nxt = S_BRANCH;
              OP_JAL:    state_nxt = S_JUMP;
              OP_JALR:   state_nxt = S_JALR_ADDR;
              OP_LUI:    state_nxt = S_LUI;
              OP_AUIPC:  state_nxt = S_ALU_WB;
              OP_LOAD,
              OP_STORE:  state_nxt = S_MEM_ADDR;
              default: begin
                state_nxt = S_TRAP;
                cause_nxt = TC_ILL;
              end
            endcase
          end
        end
        S_EXEC_R: begin
          alu_src_a   = SA_A;
          alu_control = dec_alu;
          state_nxt   = S_ALU_WB;
        end
        S_EXEC_I: begin
          alu_src_a   = SA_A;
          alu_src_b   = SB_IMM;
          alu_control = dec_alu;
          state_nxt   = S_ALU_WB;
        end
        S_LUI: begin
          alu_src_a  = SA_ZERO;
          alu_src_b  = SB_IMM;
          imm_src    = IMM_U;
          result_src = RES_ALU;
          reg_write  = 1'b1;
          state_nxt  = S_FETCH;
        end
        S_ALU_WB: begin
          reg_write = 1'b1;
          state_nxt = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a   = SA_A;
          alu_control = ALU_SUB;
          pc_write    = br_take;
          state_nxt   = S_FETCH;
        end
        S_JALR_ADDR: begin
          alu_src_a = SA_A;
          alu_src_b = SB_IMM;
          state_nxt = S_JUMP;
        end
        S_JUMP: begin
          alu_src_a = SA_OLDPC;
          alu_src_b = SB_FOUR;
          pc_write  = 1'b1;
          state_nxt = S_ALU_WB;
        end
        S_MEM_ADDR: begin
          alu_src_a = SA_A;
          alu_src_b = SB_IMM;
          if (op == OP_STORE) begin
            imm_src   = IMM_S;
            state_nxt = S_MEM_WR;
          end else begin
            state_nxt = S_MEM_RD;
          end
        end
        S_MEM_RD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
          if (mem_ready) begin
            state_nxt = S_MEM_WB;
          end else if (tmo) begin
            state_nxt = S_TRAP;
            cause_nxt = TC_TMO;
          end
        end
        S_MEM_WB: begin
          result_src = RES_DATA;
          reg_write  = 1'b1;
          state_nxt  = S_FETCH;
        end
        S_MEM_WR: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          adr_src   = 1'b1;
          if (mem_ready) begin
            state_nxt = S_FETCH;
          end else if (tmo) begin
            state_nxt = S_TRAP;
            cause_nxt = TC_TMO;
          end
        end
        S_TRAP: begin
          halted = 1'b1;
        end
        default: begin
          state_nxt = S_TRAP;
          cause_nxt = TC_ILL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_FETCH;
      wcnt       <= '0;
      trap_cause <= TC_NONE;
    end else begin
      state <= state_nxt;
      wcnt  <= (waiting && state_nxt == state) ?
               wcnt_inc : '0;
      if (state_nxt == S_TRAP && state != S_TRAP)
        trap_cause <= cause_nxt;
    end
  end

`ifdef MC_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret <= '0;
    end else if (state_nxt == S_FETCH &&
                 state != S_FETCH &&
                 state != S_TRAP) begin
      instret <= instret + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end
`endif

endmodule

// File: tb/tb_mc_controller_hs.sv
// tb_mc_controller_hs: directed vectors for the multicycle
// controller, built with a 3-bit memory wait counter.
module tb_mc_controller_hs;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero, lt, ltu, mem_ready;
  logic       mem_req, mem_write, adr_src;
  logic       ir_write, pc_write, reg_write, halted;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [1:0] trap_cause;
  logic [2:0] imm_src;
  logic [3:0] alu_control;
`ifdef MC_PERF_CNT_EN
  logic [31:0] instret;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mc_controller_hs #(.TIMEOUT_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .op          (op),
    .funct3      (funct3),
    .funct7      (funct7),
    .zero        (zero),
    .lt          (lt),
    .ltu         (ltu),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_write   (mem_write),
    .adr_src     (adr_src),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .reg_write   (reg_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .imm_src     (imm_src),
    .alu_control (alu_control),
    .halted      (halted),
    .trap_cause  (trap_cause)
`ifdef MC_PERF_CNT_EN
    , .instret   (instret)
`endif
  );

  // {f3, zero, lt, ltu, taken}
  logic [6:0] btab [8] = '{
    7'b1010001, 7'b1010100, 7'b1100000, 7'b1100011,
    7'b0001001, 7'b0011000, 7'b1110010, 7'b1000101
  };

  // {op, f3, f7, alu_control}
  logic [20:0] atab [8] = '{
    {7'h33, 3'd1, 7'h00, 4'd7},
    {7'h33, 3'd5, 7'h20, 4'd9},
    {7'h13, 3'd5, 7'h20, 4'd9},
    {7'h13, 3'd3, 7'h00, 4'd4},
    {7'h33, 3'd2, 7'h00, 4'd5},
    {7'h33, 3'd6, 7'h00, 4'd3},
    {7'h13, 3'd4, 7'h00, 4'd6},
    {7'h33, 3'd7, 7'h00, 4'd2}
  };

  // {op, f3, f7} encodings that must trap
  logic [16:0] itab [8] = '{
    {7'h7F, 3'd0, 7'h00},
    {7'h33, 3'd0, 7'h01},
    {7'h33, 3'd1, 7'h20},
    {7'h13, 3'd1, 7'h20},
    {7'h63, 3'd2, 7'h00},
    {7'h23, 3'd0, 7'h00},
    {7'h67, 3'd1, 7'h00},
    {7'h13, 3'd5, 7'h40}
  };

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return {10'd0, mem_req, mem_write, adr_src,
            ir_write, pc_write, reg_write, halted,
            result_src, alu_src_a, alu_src_b,
            imm_src, alu_control, trap_cause};
  endfunction

  // leaves the DUT mid-cycle in FETCH with mem_ready low
  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    #1;
    chk("rst_outs", outs(), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_fetch_req", mem_req, 1);
    chk("rst_cause", trap_cause, 0);
  endtask

  // completes FETCH; returns at the start of DECODE
  task automatic run_fetch(input logic [6:0] o,
                           input logic [2:0] f3,
                           input logic [6:0] f7);
    op = o;
    funct3 = f3;
    funct7 = f7;
    mem_ready = 1'b1;
    #1;
    chk("fetch_irw", ir_write, 1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1);
  end

  initial begin
    logic [6:0]  b;
    logic [20:0] a;
    logic [16:0] il;
    rst = 1'b1;
    op = 7'h0;
    funct3 = 3'h0;
    funct7 = 7'h0;
    zero = 1'b0;
    lt = 1'b0;
    ltu = 1'b0;
    mem_ready = 1'b1;
    tick();
    do_reset();

    // fetch with ready delayed three cycles, then sub x3,x1,x2
    op = 7'h33;
    funct3 = 3'd0;
    funct7 = 7'h20;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      chk("fd_req", mem_req, 1);
      chk("fd_irw", ir_write, i == 3);
      chk("fd_pcw", pc_write, i == 3);
      if (i == 3) begin
        chk("fd_srca", alu_src_a, 0);
        chk("fd_srcb", alu_src_b, 2);
        chk("fd_res", result_src, 2);
      end
      tick();
    end
    #1;
    chk("dec_srca", alu_src_a, 1);
    chk("dec_srcb", alu_src_b, 1);
    chk("dec_req", mem_req, 0);
    tick();
    #1;
    chk("sub_alu", alu_control, 1);
    chk("sub_srca", alu_src_a, 2);
    chk("sub_srcb", alu_src_b, 0);
    chk("sub_rw_ex", reg_write, 0);
    tick();
    #1;
    chk("sub_wb_rw", reg_write, 1);
    chk("sub_wb_res", result_src, 0);
    tick();
    #1;
    chk("sub_back_fetch", mem_req, 1);

    // branch conditions
    for (int i = 0; i < 8; i++) begin
      b = btab[i];
      run_fetch(7'h63, b[6:4], 7'h00);
      #1;
      chk("br_dec_imm", imm_src, 2);
      tick();
      zero = b[3];
      lt = b[2];
      ltu = b[1];
      #1;
      chk("br_alu", alu_control, 1);
      chk($sformatf("br_pcw_%0d", i), pc_write, b[0]);
      tick();
    end

    // ALU decode for R and I forms
    for (int i = 0; i < 8; i++) begin
      a = atab[i];
      run_fetch(a[20:14], a[13:11], a[10:4]);
      tick();
      #1;
      chk($sformatf("alu_%0d", i), alu_control, a[3:0]);
      chk("alu_srcb", alu_src_b,
          (a[20:14] == 7'h33) ? 0 : 1);
      tick();
      tick();
    end

    // sw with two not-ready cycles
    run_fetch(7'h23, 3'd2, 7'h00);
    #1;
    chk("sw_dec_rw", reg_write, 0);
    tick();
    #1;
    chk("sw_addr_imm", imm_src, 1);
    chk("sw_addr_srca", alu_src_a, 2);
    tick();
    for (int i = 0; i < 3; i++) begin
      mem_ready = (i == 2);
      #1;
      chk("sw_req", mem_req, 1);
      chk("sw_wr", mem_write, 1);
      chk("sw_adr", adr_src, 1);
      chk("sw_rw", reg_write, 0);
      tick();
    end
    #1;
    chk("sw_fetch_adr", adr_src, 0);
    chk("sw_fetch_wr", mem_write, 0);

    // lw
    run_fetch(7'h03, 3'd2, 7'h00);
    tick();
    #1;
    chk("lw_addr_imm", imm_src, 0);
    tick();
    mem_ready = 1'b1;
    #1;
    chk("lw_rd_adr", adr_src, 1);
    chk("lw_rd_wr", mem_write, 0);
    tick();
    #1;
    chk("lw_wb_res", result_src, 1);
    chk("lw_wb_rw", reg_write, 1);
    tick();

    // auipc goes straight to writeback
    run_fetch(7'h17, 3'd0, 7'h00);
    #1;
    chk("auipc_imm", imm_src, 3);
    tick();
    #1;
    chk("auipc_rw", reg_write, 1);
    tick();

    // reset in the middle of a store
    run_fetch(7'h23, 3'd2, 7'h00);
    tick();
    tick();
    mem_ready = 1'b0;
    #1;
    chk("abort_wr_pre", mem_write, 1);
    rst = 1'b1;
    mem_ready = 1'b1;
    #1;
    chk("abort_outs", outs(), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("abort_fetch_adr", adr_src, 0);
    chk("abort_fetch_req", mem_req, 1);

    // illegal encodings trap and stay trapped
    for (int i = 0; i < 8; i++) begin
      il = itab[i];
      run_fetch(il[16:10], il[9:7], il[6:0]);
      tick();
      mem_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
        #1;
        chk($sformatf("ill_hlt_%0d", i), halted, 1);
        chk("ill_cause", trap_cause, 1);
        chk("ill_req", mem_req, 0);
        tick();
      end
      do_reset();
    end

    // ready arriving on the seventh wait cycle still wins
    for (int i = 0; i < 7; i++) begin
      mem_ready = (i == 6);
      #1;
      chk("rdy_win_irw", ir_write, i == 6);
      tick();
    end
    #1;
    chk("rdy_win_hlt", halted, 0);
    do_reset();

    // memory timeout in FETCH after seven wait cycles
`ifdef MC_PERF_CNT_EN
    chk("instret_rst", instret, 0);
    run_fetch(7'h17, 3'd0, 7'h00);
    tick();
    tick();
    chk("instret_one", instret, 1);
`endif
    mem_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      #1;
      chk("tmo_wait_hlt", halted, 0);
      chk("tmo_wait_req", mem_req, 1);
      tick();
    end
    #1;
    chk("tmo_hlt", halted, 1);
    chk("tmo_cause", trap_cause, 2);
    chk("tmo_req", mem_req, 0);
`ifdef MC_PERF_CNT_EN
    chk("tmo_instret", instret, 1);
`endif
    tick();
    #1;
    chk("tmo_sticky", halted, 1);
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
